// File: rtl/vred_logic_seq.sv
// Sequencer for vredand/vredor/vredxor: folds a multi-beat stream of masked lanes plus a scalar seed into one result.
// Optional macro VRED_LOGIC_PIPE_EN inserts a register stage between the lane fold and the accumulator.
module vred_logic_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int LANES       = 4,
   parameter int OPSEL_WIDTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic [LANES-1:0]            in_mask,
   input  logic                        in_last,
   input  logic [OPSEL_WIDTH-1:0]      in_opSel,
   input  logic [DATA_WIDTH-1:0]       in_init,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data
);

   localparam int LEVELS = $clog2(LANES);
   localparam logic [OPSEL_WIDTH-1:0] OP_AND = OPSEL_WIDTH'(1);
   localparam logic [OPSEL_WIDTH-1:0] OP_OR  = OPSEL_WIDTH'(2);
   localparam logic [OPSEL_WIDTH-1:0] OP_XOR = OPSEL_WIDTH'(3);

`ifdef VRED_LOGIC_PIPE_EN
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif

   state_t                 state_reg;
   logic [DATA_WIDTH-1:0]  acc_reg;
   logic [OPSEL_WIDTH-1:0] op_reg;
   logic [OPSEL_WIDTH-1:0] fold_op;
   logic [DATA_WIDTH-1:0]  fold_ident;
   logic [DATA_WIDTH-1:0]  fold_val;
   logic                   accept;

   // Invalid op (00) collapses everything to zero, which forces the final result to 0.
   function automatic logic [DATA_WIDTH-1:0] apply_op(input logic [OPSEL_WIDTH-1:0] op,
                                                      input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return '0;
      endcase
   endfunction

   assign in_ready   = (state_reg == IDLE) || (state_reg == ACCUM);
   assign accept     = in_valid && in_ready;
   // The first beat has no latched op yet, so it folds with the op on the bus.
   assign fold_op    = (state_reg == IDLE) ? in_opSel : op_reg;
   assign fold_ident = (fold_op == OP_AND) ? '1 : '0;

   genvar gi, gj;
   generate
      for (gi = 0; gi <= LEVELS; gi++) begin : lvl
         logic [DATA_WIDTH-1:0] node [LANES >> gi];
         for (gj = 0; gj < (LANES >> gi); gj++) begin : nd
            if (gi == 0) begin : g_leaf
               assign node[gj] = in_mask[gj] ? in_data[gj*DATA_WIDTH +: DATA_WIDTH] : fold_ident;
            end else begin : g_join
               assign node[gj] = apply_op(fold_op, lvl[gi-1].node[2*gj], lvl[gi-1].node[2*gj+1]);
            end
         end
      end
   endgenerate

   assign fold_val = lvl[LEVELS].node[0];

`ifdef VRED_LOGIC_PIPE_EN
   logic [DATA_WIDTH-1:0] pipe_data_reg;
   logic                  pipe_valid_reg;
   logic                  pipe_last_reg;
   logic [DATA_WIDTH-1:0] absorb_val;

   assign absorb_val = apply_op(op_reg, acc_reg, pipe_data_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         op_reg         <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         pipe_data_reg  <= '0;
         pipe_valid_reg <= 1'b0;
         pipe_last_reg  <= 1'b0;
      end else begin
         pipe_valid_reg <= accept;
         if (accept) begin
            pipe_data_reg <= fold_val;
            pipe_last_reg <= in_last;
         end
         // The pipe is always empty in IDLE, so absorption never collides with the seed load.
         if (pipe_valid_reg)
            acc_reg <= absorb_val;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg    <= in_opSel;
                  acc_reg   <= in_init;
                  state_reg <= in_last ? DRAIN : ACCUM;
               end
            end
            ACCUM: begin
               if (accept && in_last)
                  state_reg <= DRAIN;
            end
            DRAIN: begin
               if (pipe_valid_reg) begin
                  state_reg <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= absorb_val;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
`else
   logic [DATA_WIDTH-1:0] acc_next;

   assign acc_next = apply_op(fold_op, (state_reg == IDLE) ? in_init : acc_reg, fold_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         op_reg    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state_reg)
            IDLE, ACCUM: begin
               if (accept) begin
                  if (state_reg == IDLE)
                     op_reg <= in_opSel;
                  acc_reg <= acc_next;
                  if (in_last) begin
                     state_reg <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= acc_next;
                  end else begin
                     state_reg <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_vred_logic_seq.sv
// Scoreboard bench for vred_logic_seq: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_vred_logic_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   in_mask;
   logic         in_last;
   logic [1:0]   in_opSel;
   logic [31:0]  in_init;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   vred_logic_seq #(.DATA_WIDTH(32), .LANES(4), .OPSEL_WIDTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mask(in_mask), .in_last(in_last), .in_opSel(in_opSel), .in_init(in_init),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   function automatic logic [127:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                      input logic [31:0] a2, input logic [31:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   // Monitor: one comparison per completed output handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
         end else begin
            chk("result", out_data, exp_q.pop_front());
         end
      end
   end

   // Called just after a posedge; returns just after the edge that accepted the beat.
   task automatic send(input logic [127:0] d, input logic [3:0] m, input logic l,
                       input logic [1:0] op, input logic [31:0] init);
      bit done = 0;
      in_valid = 1'b1; in_data = d; in_mask = m; in_last = l; in_opSel = op; in_init = init;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !out_valid;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL result_timeout: got pending=%0d expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0;
      in_opSel = '0; in_init = '0; out_ready = 1'b1;
      #12;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
      chk("reset_out_data",  out_data,           32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // XOR single beat, latency check
      exp_q.push_back(32'h0000000F);
      send(pk(1, 2, 4, 8), 4'hF, 1'b1, 2'b11, 32'h0);
`ifdef VRED_LOGIC_PIPE_EN
      @(negedge clk);
`endif
      @(negedge clk);
      chk("xor_latency_out_valid", {31'd0, out_valid}, 32'd1);
      wait_idle();

      // AND, two beats with masked lanes taking the all-ones identity
      exp_q.push_back(32'hF0FF00F0);
      send(pk(32'hFFFF00FF, 32'hF0FFFFFF, 0, 0), 4'b0011, 1'b0, 2'b01, 32'hFFFFFFFF);
      send(pk(32'hFFFFFFF0, 0, 0, 0),             4'b0001, 1'b1, 2'b10, 32'h0);
      wait_idle();

      // OR, every lane masked over three beats: seed passes through
      exp_q.push_back(32'h00000005);
      send(pk(32'hFF, 32'hFF00, 1, 2), 4'b0000, 1'b0, 2'b10, 32'h5);
      send(pk(32'h1, 32'h2, 4, 8),     4'b0000, 1'b0, 2'b01, 32'h0);
      send(pk(32'hFFFFFFFF, 3, 5, 7),  4'b0000, 1'b1, 2'b11, 32'h0);
      wait_idle();

      // XOR, partial masks, empty-mask beat, later opSel ignored
      exp_q.push_back(32'h00000061);
      send(pk(32'h0F, 32'hF0, 32'h11, 32'h22), 4'b0101, 1'b0, 2'b11, 32'hFF);
      send(pk(32'h5, 32'h6, 32'h7, 32'h8),     4'b0000, 1'b0, 2'b01, 32'h0);
      send(pk(32'h100, 32'h1, 32'h2, 32'h80),  4'b1000, 1'b1, 2'b01, 32'h0);
      wait_idle();

      // Invalid op forces zero
      exp_q.push_back(32'h00000000);
      send(pk(32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0), 4'hF, 1'b0, 2'b00, 32'hFFFF);
      send(pk(32'hAAAA, 32'h5555, 32'h1, 32'h2),       4'hF, 1'b1, 2'b00, 32'h0);
      wait_idle();

      // Backpressure: result held, no beat consumed while DONE
      out_ready = 1'b0;
      exp_q.push_back(32'h00000014);
      send(pk(1, 2, 3, 4), 4'hF, 1'b1, 2'b11, 32'h10);
      in_valid = 1'b1; in_last = 1'b1; in_data = pk(32'hFF, 32'hFF, 32'hFF, 32'hFF);
      in_mask = 4'hF; in_opSel = 2'b11; in_init = 32'h0;
`ifdef VRED_LOGIC_PIPE_EN
      @(negedge clk);
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
         chk("bp_out_data",  out_data,           32'h14);
      end
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      wait_idle();

      // Asynchronous reset mid-accumulation, then a clean reduction
      send(pk(32'hAA, 0, 0, 0), 4'hF, 1'b0, 2'b11, 32'h0);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_data",  out_data,           32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(32'h00000002);
      send(pk(32'h1, 0, 0, 0), 4'hF, 1'b1, 2'b11, 32'h3);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
